// File: rtl/fft16_bitrev_reorder_pkg.sv
// Shared constants and helpers for the 16-point FFT datapath.
// bitrev4 is the single source of truth for bit-reversed addressing so that
// reorder buffers and twiddle-address generators cannot disagree.
package fft16_bitrev_reorder_pkg;

    localparam int FFT_N        = 16;
    localparam int FFT_LOG2_N   = 4;
    localparam int FFT_SAMPLE_W = 8;

    // Reverse the four address bits: b3 b2 b1 b0 -> b0 b1 b2 b3.
    function automatic logic [FFT_LOG2_N-1:0] bitrev4(input logic [FFT_LOG2_N-1:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

endpackage

// File: rtl/fft16_bitrev_reorder_if.sv
// Stream bundle around the reorder stage: bit-reversed input side and
// natural-order output side, each with its own valid/ready handshake.
// The slave modport is the reorder block; master is its environment.
interface fft16_bitrev_reorder_if
    import fft16_bitrev_reorder_pkg::*;
#(
    parameter int W = FFT_SAMPLE_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_i;
    logic signed [W-1:0]   in_q;

    logic                  out_valid;
    logic                  out_ready;
    logic signed [W-1:0]   out_i;
    logic signed [W-1:0]   out_q;
    logic                  out_last;
    logic [FFT_LOG2_N-1:0] out_idx;

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_i, out_q, out_last, out_idx
    );

    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_i, out_q, out_last, out_idx
    );
endinterface

// File: rtl/fft16_bitrev_reorder_bank.sv
// One 16-entry complex register bank: synchronous write, asynchronous read.
// Entries have no reset; the owner's full flags decide when contents are valid.
module fft16_reorder_bank
    import fft16_bitrev_reorder_pkg::*;
#(
    parameter int W = FFT_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [FFT_LOG2_N-1:0] waddr,
    input  logic signed [W-1:0]   wdata_i,
    input  logic signed [W-1:0]   wdata_q,
    input  logic [FFT_LOG2_N-1:0] raddr,
    output logic signed [W-1:0]   rdata_i,
    output logic signed [W-1:0]   rdata_q
);
    logic signed [W-1:0] mem_i [FFT_N];
    logic signed [W-1:0] mem_q [FFT_N];

    // Store one complex sample at the given address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_i[waddr] <= wdata_i;
            mem_q[waddr] <= wdata_q;
        end
    end

    assign rdata_i = mem_i[raddr];
    assign rdata_q = mem_q[raddr];
endmodule

// File: rtl/fft16_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 16-point FFT output.
// Two ping-pong banks: the writer fills one at bitrev4(index) while the reader
// streams the other in natural order, giving 1 sample/cycle sustained.
// Optional build macro FFT16_REORDER_OVF_FLAG_EN adds a sticky ovf_flag output
// that records any input offered while the buffer could not accept it.
module fft16_bitrev_reorder
    import fft16_bitrev_reorder_pkg::*;
#(
    parameter int SAMPLE_WORD_LENGTH = FFT_SAMPLE_W,
    parameter int LOG2_N             = FFT_LOG2_N
) (
    input  logic                   clk,
    input  logic                   rst,
    fft16_bitrev_reorder_if.slave  bus
`ifdef FFT16_REORDER_OVF_FLAG_EN
    ,
    output logic                   ovf_flag
`endif
);
    generate
        if (LOG2_N != 4) begin : g_bad_log2n
            $error("fft16_bitrev_reorder supports only LOG2_N = 4");
        end
    endgenerate

    logic [3:0] wr_cnt_reg;
    logic       wr_bank_reg;
    logic [3:0] rd_cnt_reg;
    logic       rd_bank_reg;
    logic [1:0] full_reg;
    logic [1:0] full_next;

    logic in_ready_w;
    logic out_valid_w;
    logic wr_fire;
    logic rd_fire;
    logic wr_wrap;
    logic rd_wrap;

    logic signed [SAMPLE_WORD_LENGTH-1:0] bank_i [2];
    logic signed [SAMPLE_WORD_LENGTH-1:0] bank_q [2];

    assign in_ready_w  = !full_reg[wr_bank_reg];
    assign out_valid_w = full_reg[rd_bank_reg];
    assign wr_fire     = bus.in_valid && in_ready_w;
    assign rd_fire     = out_valid_w && bus.out_ready;
    assign wr_wrap     = wr_fire && (wr_cnt_reg == 4'd15);
    assign rd_wrap     = rd_fire && (rd_cnt_reg == 4'd15);

    // Ping-pong banks; only the bank currently being filled sees write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            fft16_reorder_bank #(
                .W(SAMPLE_WORD_LENGTH)
            ) u_bank (
                .clk     (clk),
                .we      (wr_fire && (wr_bank_reg == 1'(gi))),
                .waddr   (bitrev4(wr_cnt_reg)),
                .wdata_i (bus.in_i),
                .wdata_q (bus.in_q),
                .raddr   (rd_cnt_reg),
                .rdata_i (bank_i[gi]),
                .rdata_q (bank_q[gi])
            );
        end
    endgenerate

    // Full-flag update: the reader finishing a frame and the writer completing
    // one always address opposite banks, so both edits apply independently.
    always_comb begin
        full_next = full_reg;
        if (rd_wrap) begin
            full_next[rd_bank_reg] = 1'b0;
        end
        if (wr_wrap) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    // Counters, bank selects and full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            rd_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
            full_reg    <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + 4'd1;
            end
            if (wr_wrap) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (rd_fire) begin
                rd_cnt_reg <= rd_cnt_reg + 4'd1;
            end
            if (rd_wrap) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            full_reg <= full_next;
        end
    end

    // Outputs are forced to zero when no frame is ready so stale bank contents
    // never leak downstream.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_i     = out_valid_w ? bank_i[rd_bank_reg] : '0;
    assign bus.out_q     = out_valid_w ? bank_q[rd_bank_reg] : '0;
    assign bus.out_idx   = rd_cnt_reg;
    assign bus.out_last  = out_valid_w && (rd_cnt_reg == 4'd15);

`ifdef FFT16_REORDER_OVF_FLAG_EN
    logic ovf_reg;

    // Sticky record of any input offered while the write bank was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (bus.in_valid && !in_ready_w) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf_flag = ovf_reg;
`endif
endmodule

// File: tb/tb_fft16_bitrev_reorder.sv
// Directed testbench for fft16_bitrev_reorder: reset values, single frame from
// a vector table, continuous streaming, backpressure with a held sample,
// mid-frame reset and (when FFT16_REORDER_OVF_FLAG_EN is defined) ovf_flag.
module tb_fft16_bitrev_reorder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft16_bitrev_reorder_if #(.W(8)) bus ();

`ifdef FFT16_REORDER_OVF_FLAG_EN
    logic ovf_flag;
`endif

    fft16_bitrev_reorder #(
        .SAMPLE_WORD_LENGTH (8),
        .LOG2_N             (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef FFT16_REORDER_OVF_FLAG_EN
        ,
        .ovf_flag (ovf_flag)
`endif
    );

    typedef struct {
        logic [7:0] in_i;
        logic [7:0] in_q;
        logic [7:0] exp_i;
        logic [7:0] exp_q;
        logic       exp_last;
    } vec_t;

    vec_t tbl [16];

    function automatic int tb_bitrev(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (3 - b));
        end
        return r;
    endfunction

    // Expected natural-order data for frame tag t, bin n.
    function automatic logic [7:0] gen_i(input int t, input int n);
        return 8'(t * 16 + n + 1);
    endfunction

    function automatic logic [7:0] gen_q(input int t, input int n);
        return 8'(0 - (t * 16 + n + 1));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer bit-reversed input k of frame t for one accepted cycle.
    task automatic push(input int t, input int k);
        bus.in_valid = 1'b1;
        bus.in_i     = gen_i(t, tb_bitrev(k));
        bus.in_q     = gen_q(t, tb_bitrev(k));
        check($sformatf("in_ready_t%0d_k%0d", t, k), 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic write_frame(input int t);
        for (int k = 0; k < 16; k++) push(t, k);
    endtask

    task automatic drain_frame(input int t);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            check($sformatf("valid_t%0d_n%0d", t, n), 32'(bus.out_valid), 1);
            check($sformatf("idx_t%0d_n%0d", t, n), 32'(bus.out_idx), n);
            check($sformatf("out_i_t%0d_n%0d", t, n), 32'($unsigned(bus.out_i)), 32'(gen_i(t, n)));
            check($sformatf("out_q_t%0d_n%0d", t, n), 32'($unsigned(bus.out_q)), 32'(gen_q(t, n)));
            check($sformatf("last_t%0d_n%0d", t, n), 32'(bus.out_last), (n == 15) ? 1 : 0);
            $display("drain t=%0d idx=%0d i=%0d q=%0d", t, bus.out_idx, bus.out_i, bus.out_q);
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_cnt;
        int out_cnt;
        bit started;
        bit drove;
        bit acc_now;
        int acc_n;

        bus.in_valid  = 1'b0;
        bus.in_i      = '0;
        bus.in_q      = '0;
        bus.out_ready = 1'b0;

        // Reset values.
        do_reset();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_i", 32'($unsigned(bus.out_i)), 0);
        check("rst_out_q", 32'($unsigned(bus.out_q)), 0);
        check("rst_out_idx", 32'(bus.out_idx), 0);
        check("rst_out_last", 32'(bus.out_last), 0);

        // Single frame from the vector table: input k carries bitrev(k)+1.
        for (int k = 0; k < 16; k++) begin
            tbl[k].in_i     = 8'(tb_bitrev(k) + 1);
            tbl[k].in_q     = 8'(0 - (tb_bitrev(k) + 1));
            tbl[k].exp_i    = 8'(k + 1);
            tbl[k].exp_q    = 8'(0 - (k + 1));
            tbl[k].exp_last = (k == 15);
        end
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_i     = tbl[k].in_i;
            bus.in_q     = tbl[k].in_q;
            check($sformatf("sf_in_ready_k%0d", k), 32'(bus.in_ready), 1);
            check($sformatf("sf_no_early_valid_k%0d", k), 32'(bus.out_valid), 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            check($sformatf("sf_valid_n%0d", n), 32'(bus.out_valid), 1);
            check($sformatf("sf_idx_n%0d", n), 32'(bus.out_idx), n);
            check($sformatf("sf_out_i_n%0d", n), 32'($unsigned(bus.out_i)), 32'(tbl[n].exp_i));
            check($sformatf("sf_out_q_n%0d", n), 32'($unsigned(bus.out_q)), 32'(tbl[n].exp_q));
            check($sformatf("sf_last_n%0d", n), 32'(bus.out_last), 32'(tbl[n].exp_last));
            $display("single idx=%0d i=%0d q=%0d last=%0d", bus.out_idx, bus.out_i, bus.out_q, bus.out_last);
            tick();
        end
        bus.out_ready = 1'b0;
        check("sf_valid_after", 32'(bus.out_valid), 0);

        // Continuous streaming: four frames, no input stall, no output gaps.
        do_reset();
        bus.out_ready = 1'b1;
        in_cnt  = 0;
        out_cnt = 0;
        started = 1'b0;
        for (int c = 0; c < 200 && out_cnt < 64; c++) begin
            drove = 1'b0;
            if (in_cnt < 64) begin
                bus.in_valid = 1'b1;
                bus.in_i     = gen_i(in_cnt / 16, tb_bitrev(in_cnt % 16));
                bus.in_q     = gen_q(in_cnt / 16, tb_bitrev(in_cnt % 16));
                check($sformatf("st_in_ready_%0d", in_cnt), 32'(bus.in_ready), 1);
                drove = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                check($sformatf("st_idx_%0d", out_cnt), 32'(bus.out_idx), out_cnt % 16);
                check($sformatf("st_out_i_%0d", out_cnt), 32'($unsigned(bus.out_i)),
                      32'(gen_i(out_cnt / 16, out_cnt % 16)));
                check($sformatf("st_out_q_%0d", out_cnt), 32'($unsigned(bus.out_q)),
                      32'(gen_q(out_cnt / 16, out_cnt % 16)));
                check($sformatf("st_last_%0d", out_cnt), 32'(bus.out_last),
                      (out_cnt % 16 == 15) ? 1 : 0);
                $display("stream out=%0d idx=%0d i=%0d", out_cnt, bus.out_idx, bus.out_i);
                out_cnt++;
                started = 1'b1;
            end else if (started) begin
                check($sformatf("st_gap_at_%0d", out_cnt), 32'(bus.out_valid), 1);
            end
            tick();
            if (drove) in_cnt++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("st_out_count", out_cnt, 64);

        // Backpressure: two frames fill both banks, the 33rd sample is held.
        do_reset();
        write_frame(5);
        write_frame(6);
        check("bp_in_ready_full", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_i     = gen_i(7, 0);
        bus.in_q     = gen_q(7, 0);
        for (int c = 0; c < 3; c++) tick();
        check("bp_in_ready_held", 32'(bus.in_ready), 0);
        check("bp_valid_held", 32'(bus.out_valid), 1);
        check("bp_idx_held", 32'(bus.out_idx), 0);
        check("bp_out_i_held", 32'($unsigned(bus.out_i)), 32'(gen_i(5, 0)));
        bus.out_ready = 1'b1;
        acc_n = -1;
        for (int n = 0; n < 32; n++) begin
            check($sformatf("bp_valid_%0d", n), 32'(bus.out_valid), 1);
            check($sformatf("bp_idx_%0d", n), 32'(bus.out_idx), n % 16);
            check($sformatf("bp_out_i_%0d", n), 32'($unsigned(bus.out_i)), 32'(gen_i(5 + n / 16, n % 16)));
            check($sformatf("bp_out_q_%0d", n), 32'($unsigned(bus.out_q)), 32'(gen_q(5 + n / 16, n % 16)));
            $display("bp out=%0d idx=%0d i=%0d", n, bus.out_idx, bus.out_i);
            acc_now = bus.in_valid && bus.in_ready;
            tick();
            if (acc_now) begin
                bus.in_valid = 1'b0;
                acc_n = n;
            end
        end
        bus.out_ready = 1'b0;
        check("bp_held_accept_at", acc_n, 16);
        check("bp_valid_after_drain", 32'(bus.out_valid), 0);
        for (int k = 1; k < 16; k++) push(7, k);
        drain_frame(7);

        // Mid-frame reset: seven stale samples discarded.
        do_reset();
        for (int k = 0; k < 7; k++) push(9, k);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid_after_rst", 32'(bus.out_valid), 0);
        check("mr_in_ready_after_rst", 32'(bus.in_ready), 1);
        write_frame(10);
        check("mr_idx_start", 32'(bus.out_idx), 0);
        drain_frame(10);
        check("mr_valid_end", 32'(bus.out_valid), 0);

`ifdef FFT16_REORDER_OVF_FLAG_EN
        // Overflow flag: dropped sample sets a sticky flag, frames intact.
        do_reset();
        check("ovf_rst", 32'(ovf_flag), 0);
        write_frame(1);
        write_frame(2);
        check("ovf_before_drop", 32'(ovf_flag), 0);
        bus.in_valid = 1'b1;
        bus.in_i     = 8'h7f;
        bus.in_q     = 8'h7f;
        tick();
        bus.in_valid = 1'b0;
        check("ovf_set", 32'(ovf_flag), 1);
        for (int c = 0; c < 3; c++) tick();
        check("ovf_sticky", 32'(ovf_flag), 1);
        drain_frame(1);
        drain_frame(2);
        check("ovf_after_drain", 32'(ovf_flag), 1);
        do_reset();
        check("ovf_cleared", 32'(ovf_flag), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
